// File: rtl/uart_pkg.sv
// uart_pkg: shared TX/RX state encoding and default baud divisor for uart_stream.
package uart_pkg;
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_e;
    localparam int DEFAULT_CLKS_PER_BIT = 234;
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: show-ahead receive FIFO; a pop frees room for a push in the same cycle.
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   valid,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CNTW = AW + 1;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic push_ok, pop_ok;
    always_comb begin
        valid   = count_q != '0;
        full    = count_q == CNTW'(DEPTH);
        pop_ok  = pop && valid;
        push_ok = push && (!full || pop_ok);
        wptr_d  = wptr_q + AW'(push_ok);
        rptr_d  = rptr_q + AW'(pop_ok);
        count_d = count_q + CNTW'(push_ok) - CNTW'(pop_ok);
        rdata   = valid ? mem_q[rptr_q] : '0;
        count   = count_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= wdata;
    end
endmodule

// File: rtl/uart_stream.sv
// uart_stream: full-duplex UART with ready/valid byte streams and an RX FIFO.
// Define UART_PARITY_EN to add an even-parity bit on TX and check it on RX.
module uart_stream
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        uart_rx,
    output logic                        uart_tx,
    input  logic [DATA_BITS-1:0]        tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic [DATA_BITS-1:0]        rx_data,
    output logic                        rx_valid,
    input  logic                        rx_ready,
    output logic [$clog2(FIFO_DEPTH):0] rx_count,
    output logic                        rx_frame_err,
    output logic                        rx_parity_err,
    output logic                        rx_overrun
);
    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0] DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);
`ifdef UART_PARITY_EN
    localparam state_e AFTER_DATA = S_PARITY;
`else
    localparam state_e AFTER_DATA = S_STOP;
`endif

    state_e tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0] tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
    logic tx_tick;
`ifdef UART_PARITY_EN
    logic tx_par_q, tx_par_d;
`endif

    assign tx_ready = tx_state_q == S_IDLE;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        tx_tick    = tx_cnt_q == BIT_LAST;
        tx_cnt_d   = (tx_state_q == S_IDLE || tx_tick) ? '0 : tx_cnt_q + CW'(1);
        uart_tx    = 1'b1;
`ifdef UART_PARITY_EN
        tx_par_d   = tx_par_q;
`endif
        case (tx_state_q)
            S_IDLE: if (tx_valid) begin
                tx_state_d = S_START;
                tx_bit_d   = '0;
                tx_sh_d    = tx_data;
`ifdef UART_PARITY_EN
                tx_par_d   = ^tx_data;
`endif
            end
            S_START: begin
                uart_tx = 1'b0;
                if (tx_tick) tx_state_d = S_DATA;
            end
            S_DATA: begin
                uart_tx = tx_sh_q[0];
                if (tx_tick) begin
                    tx_sh_d  = tx_sh_q >> 1;
                    tx_bit_d = tx_bit_q + 3'(1);
                    if (tx_bit_q == DATA_LAST) begin
                        tx_state_d = AFTER_DATA;
                        tx_bit_d   = '0;
                    end
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
                uart_tx = tx_par_q;
                if (tx_tick) tx_state_d = S_STOP;
            end
`endif
            S_STOP: if (tx_tick) begin
                tx_bit_d = tx_bit_q + 3'(1);
                if (tx_bit_q == STOP_LAST) tx_state_d = S_IDLE;
            end
            default: tx_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_sh_q    <= '0;
`ifdef UART_PARITY_EN
            tx_par_q   <= 1'b0;
`endif
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_sh_q    <= tx_sh_d;
`ifdef UART_PARITY_EN
            tx_par_q   <= tx_par_d;
`endif
        end
    end

    logic [1:0] rx_sync_q;
    logic rx_line;
    state_e rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0] rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
    logic rx_tick, rx_par_bad;
    logic push_q, push_d, ferr_q, ferr_d, perr_q, perr_d;
    logic fifo_full;
`ifdef UART_PARITY_EN
    logic rx_par_q, rx_par_d;
    assign rx_par_bad = ^{rx_sh_q, rx_par_q};
`else
    assign rx_par_bad = 1'b0;
`endif

    assign rx_line = rx_sync_q[1];

    // START waits half a bit so every later sample lands mid-bit.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        push_d     = 1'b0;
        ferr_d     = 1'b0;
        perr_d     = 1'b0;
        rx_tick    = rx_cnt_q == (rx_state_q == S_START ? HALF_LAST : BIT_LAST);
        rx_cnt_d   = (rx_state_q == S_IDLE || rx_tick) ? '0 : rx_cnt_q + CW'(1);
`ifdef UART_PARITY_EN
        rx_par_d   = rx_par_q;
`endif
        case (rx_state_q)
            S_IDLE: if (!rx_line) begin
                rx_state_d = S_START;
                rx_bit_d   = '0;
            end
            S_START: if (rx_tick) rx_state_d = rx_line ? S_IDLE : S_DATA;
            S_DATA: if (rx_tick) begin
                rx_sh_d  = {rx_line, rx_sh_q[DATA_BITS-1:1]};
                rx_bit_d = rx_bit_q + 3'(1);
                if (rx_bit_q == DATA_LAST) rx_state_d = AFTER_DATA;
            end
`ifdef UART_PARITY_EN
            S_PARITY: if (rx_tick) begin
                rx_par_d   = rx_line;
                rx_state_d = S_STOP;
            end
`endif
            S_STOP: if (rx_tick) begin
                rx_state_d = S_IDLE;
                ferr_d     = !rx_line;
                perr_d     = rx_par_bad;
                push_d     = rx_line && !rx_par_bad;
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sync_q  <= 2'b11;
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            push_q     <= 1'b0;
            ferr_q     <= 1'b0;
            perr_q     <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par_q   <= 1'b0;
`endif
        end else begin
            rx_sync_q  <= {rx_sync_q[0], uart_rx};
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            push_q     <= push_d;
            ferr_q     <= ferr_d;
            perr_q     <= perr_d;
`ifdef UART_PARITY_EN
            rx_par_q   <= rx_par_d;
`endif
        end
    end

    assign rx_frame_err  = ferr_q;
    assign rx_parity_err = perr_q;
    // A pop in the push cycle makes room, so only a full FIFO without pop overruns.
    assign rx_overrun    = push_q && fifo_full && !rx_ready;

    uart_rx_fifo #(
        .WIDTH(DATA_BITS),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push_q),
        .wdata(rx_sh_q),
        .pop  (rx_ready),
        .rdata(rx_data),
        .valid(rx_valid),
        .full (fifo_full),
        .count(rx_count)
    );
endmodule

// File: tb/tb_uart_stream.sv
// tb_uart_stream: directed and randomized checks of uart_stream against a frame-level model.
module tb_uart_stream;
    localparam int CPB = 8;
`ifdef UART_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int NBITS = 10 + P;
    localparam int FRAME = NBITS * CPB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx_drv = 1'b1;
    logic loop = 1'b0;
    logic uart_rx, uart_tx, tx_valid, tx_ready, rx_valid, rx_ready;
    logic [7:0] tx_data, rx_data;
    logic [2:0] rx_count;
    logic rx_frame_err, rx_parity_err, rx_overrun;

    int checks = 0, errors = 0;
    int fe_cnt = 0, pe_cnt = 0, ov_cnt = 0;
    int low, ov_exp;
    logic [127:0] obs;
    logic [7:0] r;
    logic [7:0] exp_q[$];

    assign uart_rx = loop ? uart_tx : rx_drv;

    uart_stream #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS(8),
        .STOP_BITS(1),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .uart_rx(uart_rx), .uart_tx(uart_tx),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_count(rx_count), .rx_frame_err(rx_frame_err),
        .rx_parity_err(rx_parity_err), .rx_overrun(rx_overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_frame_err) fe_cnt++;
        if (rx_parity_err) pe_cnt++;
        if (rx_overrun) ov_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, o, e);
        end
    endtask

    // Serial line level of frame bit k: start, LSB-first data, optional even parity, stop.
    function automatic logic line_bit(input logic [7:0] b, input int k, input logic stop, input logic flip);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (P == 1 && k == 9) return ^b ^ flip;
        return stop;
    endfunction

    function automatic logic [127:0] tx_wave(input logic [7:0] b);
        logic [127:0] w = '0;
        for (int t = 0; t < FRAME; t++) w[t] = line_bit(b, t / CPB, 1'b1, 1'b0);
        return w;
    endfunction

    task automatic send_rx(input logic [7:0] b, input logic stop, input logic flip);
        for (int k = 0; k < NBITS; k++) begin
            rx_drv = line_bit(b, k, stop, flip);
            repeat (CPB) @(negedge clk);
        end
        rx_drv = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] e);
        chk(tag, rx_data, e);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic loop_byte(input logic [7:0] b);
        int k = 0;
        loop = 1'b1;
        while (!tx_ready && k < 200) begin @(negedge clk); k++; end
        tx_data = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        k = 0;
        while (!rx_valid && k < 400) begin @(negedge clk); k++; end
        chk("loopback rx_valid", rx_valid, 1);
        repeat (CPB) @(negedge clk);
    endtask

    initial begin
        tx_data = '0;
        tx_valid = 1'b0;
        rx_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset uart_tx", uart_tx, 1);
        chk("reset tx_ready", tx_ready, 1);
        chk("reset rx_valid", rx_valid, 0);
        chk("reset rx_data", rx_data, 0);
        chk("reset rx_count", rx_count, 0);
        chk("reset pulses", {rx_frame_err, rx_parity_err, rx_overrun}, 0);
        rst = 1'b0;
        @(negedge clk);

        tx_data = 8'h4C;
        tx_valid = 1'b1;
        chk("tx_ready idle", tx_ready, 1);
        @(negedge clk);
        tx_data = 8'h75;
        obs = '0;
        low = 0;
        for (int t = 0; t < FRAME; t++) begin
            obs[t] = uart_tx;
            if (!tx_ready) low++;
            @(negedge clk);
        end
        chk("tx frame 4C", obs, tx_wave(8'h4C));
        chk("tx_ready low cycles 4C", low, FRAME);
        chk("tx gap uart_tx", uart_tx, 1);
        chk("tx gap tx_ready", tx_ready, 1);
        @(negedge clk);
        tx_valid = 1'b0;
        obs = '0;
        low = 0;
        for (int t = 0; t < FRAME; t++) begin
            obs[t] = uart_tx;
            if (!tx_ready) low++;
            @(negedge clk);
        end
        chk("tx frame 75", obs, tx_wave(8'h75));
        chk("tx_ready low cycles 75", low, FRAME);
        chk("tx idle after", {uart_tx, tx_ready}, 2'b11);

        loop_byte(8'hA5);
        chk("loopback A5 data", rx_data, 8'hA5);
        chk("loopback A5 count", rx_count, 1);
        chk("loopback no pulses", fe_cnt + pe_cnt + ov_cnt, 0);
        pop_chk("loopback A5 pop", 8'hA5);
        chk("empty after pop", rx_valid, 0);
        for (int i = 0; i < 4; i++) begin
            r = 8'($urandom);
            loop_byte(r);
            pop_chk("loopback random", r);
        end
        chk("loopback random empty", rx_count, 0);
        chk("loopback random no pulses", fe_cnt + pe_cnt + ov_cnt, 0);
        loop = 1'b0;

        send_rx(8'h55, 1'b0, 1'b0);
        chk("frame_err pulses", fe_cnt, 1);
        chk("frame_err no push", rx_count, 0);

        rx_drv = 1'b0;
        repeat (3) @(negedge clk);
        rx_drv = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        chk("glitch no push", rx_count, 0);
        chk("glitch no pulse", fe_cnt + pe_cnt + ov_cnt, 1);
        send_rx(8'h31, 1'b1, 1'b0);
        chk("after glitch count", rx_count, 1);
        pop_chk("after glitch data", 8'h31);

        ov_exp = 0;
        for (int i = 1; i <= 5; i++) begin
            send_rx(8'(i), 1'b1, 1'b0);
            if (exp_q.size() < 4) exp_q.push_back(8'(i));
            else ov_exp++;
        end
        chk("overrun count", rx_count, exp_q.size());
        chk("overrun pulses", ov_cnt, ov_exp);
        while (exp_q.size() > 0) pop_chk("fifo order", exp_q.pop_front());
        chk("fifo drained", rx_valid, 0);

`ifdef UART_PARITY_EN
        send_rx(8'h03, 1'b1, 1'b1);
        chk("parity_err pulses", pe_cnt, 1);
        chk("parity_err no push", rx_count, 0);
        send_rx(8'h03, 1'b0, 1'b1);
        chk("both errors parity", pe_cnt, 2);
        chk("both errors frame", fe_cnt, 2);
        send_rx(8'h03, 1'b1, 1'b0);
        chk("good parity push", rx_count, 1);
        pop_chk("good parity data", 8'h03);
`else
        chk("no parity pulses", pe_cnt, 0);
`endif

        r = 8'($urandom);
        loop_byte(r);
        chk("pre-reset count", rx_count, 1);
        tx_data = 8'hC3;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (20) @(negedge clk);
        chk("mid-frame busy", tx_ready, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("reset mid-tx uart_tx", uart_tx, 1);
        chk("reset mid-tx tx_ready", tx_ready, 1);
        chk("reset flush count", rx_count, 0);
        chk("reset flush valid", rx_valid, 0);
        rst = 1'b0;
        @(negedge clk);
        loop_byte(8'h5A);
        pop_chk("after reset loopback", 8'h5A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
